path_tracer: RTL
================

# path_tracer

Reads a finished predecessor table out of the dual-port path memory and emits the shortest path from source to destination as a node stream. Runs after the Dijkstra relaxation engine has finished filling the memory. Owns one memory port in read-only mode. Walks predecessor pointers backward from the destination into an internal LIFO. Replays the LIFO forward over a valid/ready stream, then reports the path length.

## Interface
- NODE_WIDTH, 5, bits per node ID; equals path memory data and address width
- MAX_NODES, 2**NODE_WIDTH, LIFO depth and hop limit
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_node  in  NODE_WIDTH  source node, latched on start
- dst_node  in  NODE_WIDTH  destination node, latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of trace (success or error)
- error  out  1  qualifies done: 1 = no valid path
- path_len  out  NODE_WIDTH+1  node count of last successful path; held until next start
- mem_addr  out  NODE_WIDTH  path memory read address (registered)
- mem_rd  out  1  high while mem_addr is being presented; for port arbitration
- mem_q  in  NODE_WIDTH  path memory read data; valid one cycle after address is sampled
- path_node  out  NODE_WIDTH  stream data, source first
- path_valid  out  1  stream valid
- path_ready  in  1  stream ready
- path_last  out  1  marks destination node (final beat)

## Operation
- Reset values: busy, done, error, mem_rd, path_valid, path_last = 0; path_node, mem_addr = 0; path_len = 0; LIFO empty; state IDLE.
- Memory contract: path memory entry holds pred(n). pred(n)==n for n != src means unreachable. Tracer never writes.
- IDLE:
  - On start: latch src/dst, push dst, cur=dst, depth=1.
  - If dst==src, go to EMIT; otherwise go to RD.
- RD: drive mem_addr=cur, mem_rd=1 for exactly one cycle, then go to WT.
- WT: p=mem_q. Checks are evaluated in this order:
  - If p==cur, go to ERR.
  - Else if depth==MAX_NODES, go to ERR (loop guard).
  - Else push p and increment depth. If p==src, go to EMIT. Otherwise set cur=p and go to RD.
- EMIT:
  - path_valid=1, path_node=LIFO top.
  - path_last=1 when depth==1.
  - On path_valid&&path_ready: pop. Stream data must stay stable while stalled.
  - After the last beat is accepted, go to FIN.
- FIN: done=1, error=0, path_len=node count, then go to IDLE.
- ERR:
  - done=1, error=1, LIFO cleared, then go to IDLE.
  - Nothing is streamed. path_len is unchanged.
- start while busy is ignored.
- Reset asserted in any state returns all outputs and state to reset values on the next edge. A partially emitted stream is dropped.

## Timing
- Hop cost: 2 cycles (RD + WT). An H-hop path takes 2H cycles from the start edge to the first path_valid.
- dst==src: path_valid rises the cycle after start; a single beat with path_last=1.
- With path_ready held high, N nodes stream in N consecutive cycles. done rises the cycle after the last beat.
- busy falls in the same cycle done falls. start is accepted on the cycle following done.
- mem_rd is never asserted outside RD.

## Configuration
- PATH_TRACER_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort high in any non-IDLE state returns to IDLE on the next edge: LIFO cleared, path_valid=0, no done pulse, path_len unchanged.
  - abort has priority over start and stream handshakes in the same cycle.
- Undefined: port absent; a trace always runs to FIN or ERR.

## Test plan
- Chain 3→7→2→9 (pred(9)=2, pred(2)=7, pred(7)=3), src=3, dst=9, ready=1 -> 6 cycles to first valid; stream 3,7,2,9 with last on 9; done, error=0, path_len=4.
- src=dst=12 -> one beat 12 with path_last=1 on the cycle after start; no mem_rd; path_len=1.
- pred(5)=5, src=0, dst=5 -> one RD/WT; done=1, error=1; no path_valid; path_len keeps its prior value.
- Cycle pred(4)=6, pred(6)=4, src=1, dst=4 -> error after depth reaches 32; no stream.
- 3→7→2→9 with path_ready toggling 1,0,0,1,... -> path_node held stable while stalled; order 3,7,2,9 preserved; start pulsed mid-stream is ignored.
- rst_n low during EMIT of a 4-node path -> next cycle all outputs are 0 and state is IDLE; a new start then traces correctly. With PATH_TRACER_ABORT_EN, abort during WT -> IDLE, no done.

Source files
------------

// File: rtl/path_tracer.sv
// Walks a finished predecessor table from dst back to src into a LIFO, then streams the
// path source-first. Define PATH_TRACER_ABORT_EN to add an abort input.
module path_tracer #(
  parameter int NODE_WIDTH = 5,
  parameter int MAX_NODES  = 2**NODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef PATH_TRACER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [NODE_WIDTH-1:0] src_node,
  input  logic [NODE_WIDTH-1:0] dst_node,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [NODE_WIDTH:0]   path_len,
  output logic [NODE_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [NODE_WIDTH-1:0] mem_q,
  output logic [NODE_WIDTH-1:0] path_node,
  output logic                  path_valid,
  input  logic                  path_ready,
  output logic                  path_last
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_EMIT, S_FIN, S_ERR} state_t;

  localparam logic [NODE_WIDTH:0]   DEPTH_MAX = (NODE_WIDTH+1)'(MAX_NODES);
  localparam logic [NODE_WIDTH:0]   ONE_D     = (NODE_WIDTH+1)'(1);
  localparam logic [NODE_WIDTH-1:0] ONE_N     = NODE_WIDTH'(1);

  state_t                state_q, state_d;
  logic [NODE_WIDTH-1:0] cur_q, cur_d;
  logic [NODE_WIDTH-1:0] src_q, src_d;
  logic [NODE_WIDTH:0]   depth_q, depth_d;
  logic [NODE_WIDTH:0]   len_q, len_d;
  logic [NODE_WIDTH:0]   path_len_q, path_len_d;
  logic [NODE_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [NODE_WIDTH-1:0] lifo_q [MAX_NODES];

  logic                  push_en;
  logic [NODE_WIDTH-1:0] push_idx;
  logic [NODE_WIDTH-1:0] push_val;
  logic [NODE_WIDTH-1:0] top_idx;
  logic                  abort_w;

`ifdef PATH_TRACER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    src_d      = src_q;
    depth_d    = depth_q;
    len_d      = len_q;
    path_len_d = path_len_q;
    mem_addr_d = mem_addr_q;
    push_en    = 1'b0;
    push_idx   = depth_q[NODE_WIDTH-1:0];
    push_val   = mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d    = src_node;
          cur_d    = dst_node;
          push_en  = 1'b1;
          push_idx = '0;
          push_val = dst_node;
          depth_d  = ONE_D;
          if (dst_node == src_node) begin
            len_d   = ONE_D;
            state_d = S_EMIT;
          end else begin
            mem_addr_d = dst_node;
            state_d    = S_RD;
          end
        end
      end
      S_RD: state_d = S_WT;
      S_WT: begin
        // Self-pointer means unreachable; a full LIFO means the table contains a cycle.
        if (mem_q == cur_q) begin
          state_d = S_ERR;
        end else if (depth_q == DEPTH_MAX) begin
          state_d = S_ERR;
        end else begin
          push_en = 1'b1;
          depth_d = depth_q + ONE_D;
          if (mem_q == src_q) begin
            len_d   = depth_q + ONE_D;
            state_d = S_EMIT;
          end else begin
            cur_d      = mem_q;
            mem_addr_d = mem_q;
            state_d    = S_RD;
          end
        end
      end
      S_EMIT: begin
        if (path_ready) begin
          depth_d = depth_q - ONE_D;
          if (depth_q == ONE_D) begin
            path_len_d = len_q;
            state_d    = S_FIN;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      S_ERR: begin
        depth_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w && state_q != S_IDLE) begin
      push_en    = 1'b0;
      depth_d    = '0;
      path_len_d = path_len_q;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      src_q      <= '0;
      depth_q    <= '0;
      len_q      <= '0;
      path_len_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      src_q      <= src_d;
      depth_q    <= depth_d;
      len_q      <= len_d;
      path_len_q <= path_len_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // LIFO storage carries no reset; depth_q alone defines its contents.
  always_ff @(posedge clk) begin
    if (push_en) begin
      lifo_q[push_idx] <= push_val;
    end
  end

  assign top_idx    = depth_q[NODE_WIDTH-1:0] - ONE_N;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN) || (state_q == S_ERR);
  assign error      = (state_q == S_ERR);
  assign mem_rd     = (state_q == S_RD);
  assign mem_addr   = mem_addr_q;
  assign path_len   = path_len_q;
  assign path_valid = (state_q == S_EMIT);
  assign path_last  = (state_q == S_EMIT) && (depth_q == ONE_D);
  assign path_node  = (state_q == S_EMIT) ? lifo_q[top_idx] : '0;

endmodule
